reverb_s2m_fifo_param: RTL and testbench
========================================

REVERB_S2M_FIFO_PARAM -- requirements
Module: reverb_s2m_fifo_param

Interface
REQ-001 Parameter DATA_W, default 32: stream and FIFO word width; legal range 8..32.
REQ-002 Parameter DEPTH_LOG2, default 5: FIFO depth is 2**DEPTH_LOG2 words; legal range 2..10.
REQ-003 Parameter DROP_ON_FULL, default 0: 0 = backpressure mode, 1 = drop mode (ready held high, excess words discarded).
REQ-004 Parameter THRESH_RST, default 2**DEPTH_LOG2-1: reset value of the threshold register.
REQ-005 wrclock  in  1  sole clock; all state changes on its rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 avalonst_sink_data  in  DATA_W  stream word.
REQ-008 avalonst_sink_valid  in  1  stream word valid.
REQ-009 avalonst_sink_ready  out  1  sink may accept a word this cycle (readyLatency 0).
REQ-010 avalonmm_read_slave_address  in  2  register select.
REQ-011 avalonmm_read_slave_read  in  1  read strobe.
REQ-012 avalonmm_read_slave_write  in  1  write strobe.
REQ-013 avalonmm_read_slave_writedata  in  32  write data.
REQ-014 avalonmm_read_slave_readdata  out  32  read data, valid in the cycle waitrequest is low.
REQ-015 avalonmm_read_slave_waitrequest  out  1  stall current access.
REQ-016 irq  out  1  level-sensitive interrupt.

Function
REQ-017 Register map: 0 DATA (R), 1 STATUS (R), 2 CONTROL (R/W), 3 THRESH (R/W); writes to 0 and 1 are ignored.
REQ-018 STATUS = {overflow_sticky[31], drop_count[23:16] (8-bit, saturating at 255), empty[15], full[14], level[DEPTH_LOG2:0] (zero-extended)}; all other bits 0.
REQ-019 CONTROL bit0 = irq_en (R/W); bit1 = flush (write-1 pulse, reads 0); bit2 = clear overflow_sticky and drop_count (write-1 pulse, reads 0).
REQ-020 THRESH holds DEPTH_LOG2+1 bits; write data above 2**DEPTH_LOG2 is saturated to 2**DEPTH_LOG2.
REQ-021 level counts stored words, 0..2**DEPTH_LOG2; empty = (level==0); full = (level==2**DEPTH_LOG2).
REQ-022 Push occurs when sink_valid & sink_ready & !full; the word is stored at the write pointer, and the pointer wraps modulo depth.
REQ-023 Backpressure mode: sink_ready = !full & !reset.
REQ-024 Drop mode: sink_ready = !reset; valid while full discards the word, sets overflow_sticky and increments drop_count.
REQ-025 DATA read is show-ahead: readdata = {zero-extend, mem[rd_ptr]}; the read completes and pops in the same cycle when !empty.
REQ-026 DATA read while empty: waitrequest = 1, no pop; it completes in the first cycle the FIFO is non-empty.
REQ-027 Register reads (1..3) and all writes: waitrequest = 0, complete in one cycle.
REQ-028 Simultaneous push and pop: level unchanged; when full in backpressure mode, push is blocked (ready low) and only the pop occurs.
REQ-029 Push and pop in the same cycle with level==0 are not possible: the read stalls, the push occurs, and the read completes in the next cycle with the pushed word.
REQ-030 Flush: pointers and level go to 0 on the clock edge of the write; a push or pop in that cycle is discarded, and overflow_sticky and drop_count are unchanged.
REQ-031 irq = irq_en & ((level >= THRESH) | overflow_sticky), registered (one-cycle lag).
REQ-032 With read and write asserted together, the write is ignored and the read proceeds.

Reset
REQ-033 While reset is high: pointers=0, level=0, empty=1, full=0, overflow_sticky=0, drop_count=0, irq_en=0, THRESH=THRESH_RST, irq=0, sink_ready=0, readdata=0, waitrequest=1.
REQ-034 Reset asserted mid-operation discards all contents immediately (asynchronously); memory contents are don't-care.

Verification
REQ-035 Defaults: push 0x11,0x22,0x33, then read addr0 x3 -> 0x11,0x22,0x33 with waitrequest=0 each; STATUS then 0x00008000.
REQ-036 Fill 32 words in backpressure mode -> full=1, sink_ready=0, STATUS[5:0]=32; one pop -> sink_ready=1 in the same cycle.
REQ-037 DROP_ON_FULL=1: push 35 words -> level 32, STATUS[31]=1, drop_count=3; write CONTROL=0x4 -> both cleared.
REQ-038 Read addr0 while empty for 5 cycles, then push 0xAB -> waitrequest high for 5 cycles plus the push cycle; the next cycle readdata=0xAB and waitrequest=0.
REQ-039 THRESH=4, CONTROL=1: push 3 -> irq=0; 4th push -> irq=1 one cycle later; CONTROL=0x3 flush -> level 0, irq=0.
REQ-040 Assert reset with level=10 mid-burst -> level=0, sink_ready=0, irq=0 immediately; after release, the first read of addr0 stalls.

Source files
------------

// File: rtl/reverb_s2m_fifo_param_if.sv
// Bundle of stream-sink and register-slave signals for reverb_s2m_fifo_param.
// The DUT uses the slave modport and the driver uses the master modport.
interface reverb_s2m_fifo_param_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] avalonst_sink_data;
  logic              avalonst_sink_valid;
  logic              avalonst_sink_ready;
  logic [1:0]        avalonmm_read_slave_address;
  logic              avalonmm_read_slave_read;
  logic              avalonmm_read_slave_write;
  logic [31:0]       avalonmm_read_slave_writedata;
  logic [31:0]       avalonmm_read_slave_readdata;
  logic              avalonmm_read_slave_waitrequest;

  modport slave (
    input  avalonst_sink_data, avalonst_sink_valid,
    output avalonst_sink_ready,
    input  avalonmm_read_slave_address, avalonmm_read_slave_read,
    input  avalonmm_read_slave_write, avalonmm_read_slave_writedata,
    output avalonmm_read_slave_readdata, avalonmm_read_slave_waitrequest
  );

  modport master (
    output avalonst_sink_data, avalonst_sink_valid,
    input  avalonst_sink_ready,
    output avalonmm_read_slave_address, avalonmm_read_slave_read,
    output avalonmm_read_slave_write, avalonmm_read_slave_writedata,
    input  avalonmm_read_slave_readdata, avalonmm_read_slave_waitrequest
  );
endinterface

// File: rtl/reverb_s2m_fifo_param.sv
// Stream-to-register FIFO: words pushed from a stream sink are popped through
// a show-ahead DATA register, with status, control, threshold and an interrupt.
module reverb_s2m_fifo_param #(
  parameter int DATA_W       = 32,
  parameter int DEPTH_LOG2   = 5,
  parameter bit DROP_ON_FULL = 1'b0,
  parameter int THRESH_RST   = 2**DEPTH_LOG2 - 1
) (
  input  logic                          wrclock,
  input  logic                          reset,
  reverb_s2m_fifo_param_if.slave        bus,
  output logic                          irq
);
  localparam int                  DEPTH      = 2**DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] C_FULL     = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] C_THR_INIT = (DEPTH_LOG2+1)'(THRESH_RST);

  logic [DATA_W-1:0]     r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_level;
  logic [DEPTH_LOG2:0]   r_thresh;
  logic [7:0]            r_drop_cnt;
  logic                  r_ovf;
  logic                  r_irq_en;
  logic                  r_irq;

  logic                  w_empty, w_full, w_push, w_pop, w_drop;
  logic                  w_data_rd, w_wr, w_flush, w_clear;
  logic [DEPTH_LOG2:0]   w_thresh_sat;
  logic [31:0]           w_status;
  logic [31:0]           w_readdata;

  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == C_FULL);

  assign bus.avalonst_sink_ready = DROP_ON_FULL ? !reset : (!w_full && !reset);

  assign w_push    = bus.avalonst_sink_valid && bus.avalonst_sink_ready && !w_full;
  assign w_drop    = DROP_ON_FULL && bus.avalonst_sink_valid && w_full && !reset;
  assign w_data_rd = bus.avalonmm_read_slave_read && (bus.avalonmm_read_slave_address == 2'd0);
  assign w_pop     = w_data_rd && !w_empty;
  // A write that collides with a read is dropped so the read always wins.
  assign w_wr      = bus.avalonmm_read_slave_write && !bus.avalonmm_read_slave_read;
  assign w_flush   = w_wr && (bus.avalonmm_read_slave_address == 2'd2) && bus.avalonmm_read_slave_writedata[1];
  assign w_clear   = w_wr && (bus.avalonmm_read_slave_address == 2'd2) && bus.avalonmm_read_slave_writedata[2];

  assign w_thresh_sat = (bus.avalonmm_read_slave_writedata > 32'(DEPTH)) ? C_FULL
                        : bus.avalonmm_read_slave_writedata[DEPTH_LOG2:0];

  assign bus.avalonmm_read_slave_waitrequest = reset || (w_data_rd && w_empty);
  assign bus.avalonmm_read_slave_readdata    = w_readdata;
  assign irq = r_irq;

  always_ff @(posedge wrclock) begin
    if (w_push && !w_flush) begin
      r_mem[r_wr_ptr] <= bus.avalonst_sink_data;
    end
  end

  always_ff @(posedge wrclock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge wrclock or posedge reset) begin
    if (reset) begin
      r_ovf      <= 1'b0;
      r_drop_cnt <= '0;
      r_irq_en   <= 1'b0;
      r_thresh   <= C_THR_INIT;
      r_irq      <= 1'b0;
    end else begin
      if (w_clear) begin
        r_ovf      <= 1'b0;
        r_drop_cnt <= '0;
      end else if (w_drop) begin
        r_ovf <= 1'b1;
        if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 1'b1;
      end
      if (w_wr && (bus.avalonmm_read_slave_address == 2'd2)) begin
        r_irq_en <= bus.avalonmm_read_slave_writedata[0];
      end
      if (w_wr && (bus.avalonmm_read_slave_address == 2'd3)) begin
        r_thresh <= w_thresh_sat;
      end
      r_irq <= r_irq_en && ((r_level >= r_thresh) || r_ovf);
    end
  end

  always_comb begin
    w_status                 = '0;
    w_status[31]             = r_ovf;
    w_status[23:16]          = r_drop_cnt;
    w_status[15]             = w_empty;
    w_status[14]             = w_full;
    w_status[DEPTH_LOG2:0]   = r_level;
  end

  always_comb begin
    w_readdata = '0;
    if (!reset) begin
      case (bus.avalonmm_read_slave_address)
        2'd0:    w_readdata[DATA_W-1:0]   = r_mem[r_rd_ptr];
        2'd1:    w_readdata               = w_status;
        2'd2:    w_readdata[0]            = r_irq_en;
        default: w_readdata[DEPTH_LOG2:0] = r_thresh;
      endcase
    end
  end
endmodule

// File: tb/tb_reverb_s2m_fifo_param.sv
// Directed bench: a backpressure and a drop-mode instance share one stimulus
// stream; results are compared against hand-computed constants.
module tb_reverb_s2m_fifo_param;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] s_data  = '0;
  logic        s_valid = 1'b0;
  logic [1:0]  s_addr  = '0;
  logic        s_read  = 1'b0;
  logic        s_write = 1'b0;
  logic [31:0] s_wdata = '0;
  logic        irq_bp, irq_dr;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  reverb_s2m_fifo_param_if #(.DATA_W(32)) bp_if ();
  reverb_s2m_fifo_param_if #(.DATA_W(32)) dr_if ();

  assign bp_if.avalonst_sink_data            = s_data;
  assign bp_if.avalonst_sink_valid           = s_valid;
  assign bp_if.avalonmm_read_slave_address   = s_addr;
  assign bp_if.avalonmm_read_slave_read      = s_read;
  assign bp_if.avalonmm_read_slave_write     = s_write;
  assign bp_if.avalonmm_read_slave_writedata = s_wdata;
  assign dr_if.avalonst_sink_data            = s_data;
  assign dr_if.avalonst_sink_valid           = s_valid;
  assign dr_if.avalonmm_read_slave_address   = s_addr;
  assign dr_if.avalonmm_read_slave_read      = s_read;
  assign dr_if.avalonmm_read_slave_write     = s_write;
  assign dr_if.avalonmm_read_slave_writedata = s_wdata;

  reverb_s2m_fifo_param #(.DATA_W(32), .DEPTH_LOG2(5), .DROP_ON_FULL(1'b0)) u_dut_bp (
    .wrclock (clk),
    .reset   (rst),
    .bus     (bp_if.slave),
    .irq     (irq_bp)
  );

  reverb_s2m_fifo_param #(.DATA_W(32), .DEPTH_LOG2(5), .DROP_ON_FULL(1'b1)) u_dut_dr (
    .wrclock (clk),
    .reset   (rst),
    .bus     (dr_if.slave),
    .irq     (irq_dr)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] w);
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = w;
    tick();
    s_valid = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d_bp, output logic [31:0] d_dr,
                    output logic w_bp);
    @(negedge clk);
    s_read = 1'b1;
    s_addr = a;
    #1;
    d_bp = bp_if.avalonmm_read_slave_readdata;
    d_dr = dr_if.avalonmm_read_slave_readdata;
    w_bp = bp_if.avalonmm_read_slave_waitrequest;
    tick();
    s_read = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    s_write = 1'b1;
    s_addr  = a;
    s_wdata = d;
    tick();
    s_write = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    tick();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] d_bp, d_dr;
    logic        w_bp;

    // reset state, held over two edges
    s_read = 1'b1;
    s_addr = 2'd1;
    tick();
    tick();
    chk("rst_ready_bp", 32'(bp_if.avalonst_sink_ready), 32'd0);
    chk("rst_ready_dr", 32'(dr_if.avalonst_sink_ready), 32'd0);
    chk("rst_wait", 32'(bp_if.avalonmm_read_slave_waitrequest), 32'd1);
    chk("rst_rdata", bp_if.avalonmm_read_slave_readdata, 32'd0);
    chk("rst_irq", 32'(irq_bp), 32'd0);
    @(negedge clk);
    s_read = 1'b0;
    rst    = 1'b0;

    // basic push / show-ahead pop
    push(32'h11); push(32'h22); push(32'h33);
    rd(2'd1, d_bp, d_dr, w_bp); chk("status_lvl3", d_bp, 32'h0000_0003);
    rd(2'd0, d_bp, d_dr, w_bp); chk("pop0_data", d_bp, 32'h11); chk("pop0_wait", 32'(w_bp), 0);
    rd(2'd0, d_bp, d_dr, w_bp); chk("pop1_data", d_bp, 32'h22); chk("pop1_wait", 32'(w_bp), 0);
    rd(2'd0, d_bp, d_dr, w_bp); chk("pop2_data", d_bp, 32'h33); chk("pop2_wait", 32'(w_bp), 0);
    rd(2'd1, d_bp, d_dr, w_bp); chk("status_empty", d_bp, 32'h0000_8000);

    // fill to full in backpressure mode (pointers wrap)
    for (int i = 0; i < 32; i++) push(32'h100 + 32'(i));
    chk("full_ready", 32'(bp_if.avalonst_sink_ready), 32'd0);
    rd(2'd1, d_bp, d_dr, w_bp); chk("status_full", d_bp, 32'h0000_4020);
    @(negedge clk);
    s_valid = 1'b1; s_data = 32'hDEAD; s_read = 1'b1; s_addr = 2'd0;
    #1;
    chk("full_pop_data", bp_if.avalonmm_read_slave_readdata, 32'h100);
    tick();
    s_valid = 1'b0; s_read = 1'b0;
    chk("ready_after_pop", 32'(bp_if.avalonst_sink_ready), 32'd1);
    rd(2'd1, d_bp, d_dr, w_bp); chk("status_lvl31", d_bp, 32'h0000_001F);
    for (int i = 1; i < 32; i++) begin
      rd(2'd0, d_bp, d_dr, w_bp);
      chk($sformatf("drain%0d", i), d_bp, 32'h100 + 32'(i));
    end
    rd(2'd1, d_bp, d_dr, w_bp); chk("status_drained", d_bp, 32'h0000_8000);

    // read stall while empty, then completion with the pushed word
    @(negedge clk);
    s_read = 1'b1; s_addr = 2'd0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("stall%0d", i), 32'(bp_if.avalonmm_read_slave_waitrequest), 32'd1);
      @(negedge clk);
    end
    s_valid = 1'b1; s_data = 32'hAB;
    #1;
    chk("stall_push_cycle", 32'(bp_if.avalonmm_read_slave_waitrequest), 32'd1);
    tick();
    s_valid = 1'b0;
    chk("stall_done_wait", 32'(bp_if.avalonmm_read_slave_waitrequest), 32'd0);
    chk("stall_done_data", bp_if.avalonmm_read_slave_readdata, 32'hAB);
    tick();
    s_read = 1'b0;
    rd(2'd1, d_bp, d_dr, w_bp); chk("status_after_stall", d_bp, 32'h0000_8000);

    // threshold interrupt, flush, saturation, read-beats-write
    wr(2'd3, 32'd4);
    wr(2'd2, 32'd1);
    rd(2'd3, d_bp, d_dr, w_bp); chk("thresh_rb", d_bp, 32'd4);
    rd(2'd2, d_bp, d_dr, w_bp); chk("control_rb", d_bp, 32'd1);
    push(32'h1); push(32'h2); push(32'h3);
    tick();
    chk("irq_lvl3", 32'(irq_bp), 32'd0);
    push(32'h4);
    chk("irq_lag", 32'(irq_bp), 32'd0);
    tick();
    chk("irq_lvl4", 32'(irq_bp), 32'd1);
    wr(2'd2, 32'h3);
    tick();
    chk("irq_after_flush", 32'(irq_bp), 32'd0);
    rd(2'd1, d_bp, d_dr, w_bp); chk("status_flushed", d_bp, 32'h0000_8000);
    rd(2'd2, d_bp, d_dr, w_bp); chk("control_pulse_rd0", d_bp, 32'd1);
    wr(2'd3, 32'd100);
    rd(2'd3, d_bp, d_dr, w_bp); chk("thresh_sat", d_bp, 32'd32);
    @(negedge clk);
    s_read = 1'b1; s_write = 1'b1; s_addr = 2'd3; s_wdata = 32'd5;
    #1;
    chk("rw_read", bp_if.avalonmm_read_slave_readdata, 32'd32);
    chk("rw_wait", 32'(bp_if.avalonmm_read_slave_waitrequest), 32'd0);
    tick();
    s_read = 1'b0; s_write = 1'b0;
    rd(2'd3, d_bp, d_dr, w_bp); chk("rw_write_ignored", d_bp, 32'd32);

    // asynchronous reset mid-burst
    wr(2'd3, 32'd4);
    for (int i = 0; i < 10; i++) push(32'h300 + 32'(i));
    chk("irq_before_rst", 32'(irq_bp), 32'd1);
    @(negedge clk);
    s_valid = 1'b1; s_data = 32'h999;
    #1;
    rst = 1'b1;
    #1;
    chk("arst_irq", 32'(irq_bp), 32'd0);
    chk("arst_ready", 32'(bp_if.avalonst_sink_ready), 32'd0);
    chk("arst_wait", 32'(bp_if.avalonmm_read_slave_waitrequest), 32'd1);
    tick();
    @(negedge clk);
    rst = 1'b0; s_valid = 1'b0;
    rd(2'd1, d_bp, d_dr, w_bp); chk("arst_status", d_bp, 32'h0000_8000);
    rd(2'd3, d_bp, d_dr, w_bp); chk("arst_thresh", d_bp, 32'd31);
    rd(2'd2, d_bp, d_dr, w_bp); chk("arst_control", d_bp, 32'd0);
    rd(2'd0, d_bp, d_dr, w_bp); chk("arst_first_read_stall", 32'(w_bp), 32'd1);

    // drop mode: 35 pushes into a 32-deep FIFO
    pulse_reset();
    for (int i = 0; i < 35; i++) push(32'h200 + 32'(i));
    chk("drop_ready_full", 32'(dr_if.avalonst_sink_ready), 32'd1);
    chk("bp_ready_full", 32'(bp_if.avalonst_sink_ready), 32'd0);
    rd(2'd1, d_bp, d_dr, w_bp);
    chk("drop_status", d_dr, 32'h8003_4020);
    chk("bp_status_no_drop", d_bp, 32'h0000_4020);
    wr(2'd2, 32'h4);
    rd(2'd1, d_bp, d_dr, w_bp); chk("drop_cleared", d_dr, 32'h0000_4020);
    rd(2'd0, d_bp, d_dr, w_bp); chk("drop_head", d_dr, 32'h200);
    chk("drop_irq", 32'(irq_dr), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
